mapper_mac_unit: RTL and testbench



---
 rtl/mapper_mac_unit.sv | 153 +++++++++++++++
 tb/tb_mapper_mac_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mapper_mac_unit.sv
// mapper_mac_unit: sequential shift-add multiply/accumulate for mapper
// arithmetic registers. Retires STEP multiplier bits per clk, optional
// two's-complement operands, accumulator with sticky overflow.
//
// state | meaning
// IDLE  | no multiply in flight, p/acc hold last results
// RUN   | partial sum being built, cnt counts iterations 0..ITER-1
module mapper_mac_unit #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int ACC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   acc_en,
  input  logic                   acc_clear,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [2*WIDTH-1:0]     p,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int ITER  = WIDTH / STEP;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [PW-1:0]        a_sh_q;
  logic [WIDTH-1:0]     b_sh_q;
  logic [PW-1:0]        psum_q;
  logic                 neg_q, sgn_q, acc_en_q;
  logic [PW-1:0]        p_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 done_q, ovf_q;

  logic                 accept, last;
  logic [WIDTH:0]       a_ext, b_ext;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [PW-1:0]        pp, sum, p_new;
  logic [ACC_WIDTH-1:0] acc_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 ovf_now;

  assign accept = ce & start;
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(ITER - 1));

  // Operand magnitudes; the extra bit keeps the most negative value exact.
  always_comb begin
    a_ext = {signed_mode & a[WIDTH-1], a};
    b_ext = {signed_mode & b[WIDTH-1], b};
    a_mag = a_ext[WIDTH] ? WIDTH'((~a_ext) + 1'b1) : a;
    b_mag = b_ext[WIDTH] ? WIDTH'((~b_ext) + 1'b1) : b;
  end

  // One partial product per clk, final sign fix and accumulator add.
  always_comb begin
    pp      = a_sh_q * {{(PW-STEP){1'b0}}, b_sh_q[STEP-1:0]};
    sum     = psum_q + pp;
    p_new   = neg_q ? ((~sum) + 1'b1) : sum;
    acc_ext = sgn_q ? ACC_WIDTH'($signed(p_new)) : ACC_WIDTH'(p_new);
    acc_sum = {1'b0, acc_q} + {1'b0, acc_ext};
    if (sgn_q)
      ovf_now = (acc_q[ACC_WIDTH-1] == acc_ext[ACC_WIDTH-1]) &&
                (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      ovf_now = acc_sum[ACC_WIDTH];
  end

  // Next-state: a start always (re)enters RUN, otherwise RUN ends on the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (accept)     state_d = RUN;
        else if (last)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Multiply datapath: operand latch, shift-add iterations, result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      psum_q   <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      acc_en_q <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Completion is honoured even if a new start lands on the same edge.
      if (last) begin
        p_q    <= p_new;
        done_q <= 1'b1;
      end
      if (accept) begin
        a_sh_q   <= {{WIDTH{1'b0}}, a_mag};
        b_sh_q   <= b_mag;
        neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        sgn_q    <= signed_mode;
        acc_en_q <= acc_en;
        psum_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN && !last) begin
        psum_q <= sum;
        a_sh_q <= a_sh_q << STEP;
        b_sh_q <= b_sh_q >> STEP;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Accumulator and sticky overflow; a clear on a completing edge keeps the new product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (ce && acc_clear) begin
      acc_q <= (last && acc_en_q) ? acc_ext : '0;
      ovf_q <= 1'b0;
    end else if (last && acc_en_q) begin
      acc_q <= acc_sum[ACC_WIDTH-1:0];
      if (ovf_now) ovf_q <= 1'b1;
    end
  end

  assign p        = p_q;
  assign acc      = acc_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mapper_mac_unit.sv
// Directed bench for mapper_mac_unit: default instance plus a STEP=4 instance
// sharing the same stimulus.
module tb_mapper_mac_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic        acc_en = 1'b0, acc_clear = 1'b0;
  logic [7:0]  a = '0, b = '0;

  logic [15:0] p, p2, acc, acc2;
  logic        busy, busy2, done, done2, overflow, overflow2;

  int n_checks = 0;
  int n_errors = 0;

  mapper_mac_unit dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .signed_mode(signed_mode), .acc_en(acc_en), .acc_clear(acc_clear),
    .a(a), .b(b), .p(p), .acc(acc), .busy(busy), .done(done),
    .overflow(overflow)
  );

  mapper_mac_unit #(.WIDTH(8), .STEP(4), .ACC_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .signed_mode(signed_mode), .acc_en(acc_en), .acc_clear(acc_clear),
    .a(a), .b(b), .p(p2), .acc(acc2), .busy(busy2), .done(done2),
    .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge right after the accepting edge S.
  task automatic do_start(input logic [7:0] ai, input logic [7:0] bi,
                          input logic sm, input logic ae);
    @(negedge clk);
    a = ai; b = bi; signed_mode = sm; acc_en = ae;
    ce = 1'b1; start = 1'b1;
    @(negedge clk);
    ce = 1'b0; start = 1'b0;
  endtask

  // Start and wait (bounded) for done on the default instance.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic sm, input logic ae);
    int cyc;
    do_start(ai, bi, sm, ae);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 8);
  endtask

  task automatic clear_acc();
    @(negedge clk);
    ce = 1'b1; acc_clear = 1'b1;
    @(negedge clk);
    ce = 1'b0; acc_clear = 1'b0;
  endtask

  initial begin
    int bad;
    int cyc;
    int done_cnt;
    int p_chg;
    logic [15:0] p_before, acc_before;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_p", p, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acc", acc, 0);
    reset = 1'b0;

    // Unsigned 0xFF x 0xFF, busy window and done pulse
    do_start(8'hFF, 8'hFF, 1'b0, 1'b0);
    check("u_busy_S", busy, 1);
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (!busy || done) bad++;
    end
    check("u_busy_window", bad, 0);
    @(negedge clk);
    check("u_p", p, 16'hFE01);
    check("u_done", done, 1);
    check("u_busy_end", busy, 0);
    @(negedge clk);
    check("u_done_once", done, 0);

    // STEP=4 instance: two-clock latency
    do_start(8'hC3, 8'h5A, 1'b0, 1'b0);
    check("s4_busy_S", busy2, 1);
    @(negedge clk);
    check("s4_done_early", done2, 0);
    @(negedge clk);
    check("s4_p", p2, 16'h448E);
    check("s4_done", done2, 1);
    check("s4_busy_end", busy2, 0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("s4_ref_p", p, 16'h448E);

    // Signed products
    run_op("sg1", 8'h80, 8'h80, 1'b1, 1'b0);
    check("sg_80x80", p, 16'h4000);
    run_op("sg2", 8'hFF, 8'h02, 1'b1, 1'b0);
    check("sg_FFx02", p, 16'hFFFE);
    run_op("sg3", 8'h7F, 8'h81, 1'b1, 1'b0);
    check("sg_7Fx81", p, 16'hC0FF);

    // Unsigned accumulate with carry-out
    clear_acc();
    check("acc_clr0", acc, 0);
    run_op("acc1", 8'hFF, 8'hFF, 1'b0, 1'b1);
    check("acc1_val", acc, 16'hFE01);
    check("acc1_ovf", overflow, 0);
    run_op("acc2", 8'hFF, 8'hFF, 1'b0, 1'b1);
    check("acc2_val", acc, 16'hFC02);
    check("acc2_ovf", overflow, 1);
    clear_acc();
    check("acc_clr_val", acc, 0);
    check("acc_clr_ovf", overflow, 0);

    // Signed accumulate: carry-out without signed overflow
    run_op("sacc1", 8'hFF, 8'h02, 1'b1, 1'b1);
    check("sacc1_val", acc, 16'hFFFE);
    run_op("sacc2", 8'h80, 8'h80, 1'b1, 1'b1);
    check("sacc2_val", acc, 16'h3FFE);
    check("sacc2_ovf", overflow, 0);

    // Restart: 3x5 at S, 7x9 at S+3, single done at S+11
    do_start(8'd3, 8'd5, 1'b0, 1'b0);
    p_before = p;
    acc_before = acc;
    repeat (2) @(negedge clk);
    a = 8'd7; b = 8'd9; ce = 1'b1; start = 1'b1;
    @(negedge clk);
    ce = 1'b0; start = 1'b0;
    done_cnt = 0;
    p_chg = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("rs_done_pos", i, 8);
        check("rs_p", p, 16'h003F);
      end else if (i < 8 && p !== p_before) begin
        p_chg++;
      end
    end
    check("rs_done_count", done_cnt, 1);
    check("rs_p_stable", p_chg, 0);
    check("rs_acc_untouched", acc, acc_before);

    // Async reset mid accumulating multiply
    do_start(8'h11, 8'h11, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_p", p, 0);
    check("ar_acc", acc, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_ovf", overflow, 0);
    check("ar_all4", {p2, acc2, busy2, done2, overflow2}, 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("ar_no_done", done_cnt, 0);
    run_op("post", 8'd2, 8'd3, 1'b0, 1'b0);
    check("post_p", p, 16'h0006);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
